// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, states,
// ALU operation codes and datapath mux selects.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// shared datapath plus memory (slave).
interface multicycle_controller_if;

    logic [6:0] OP;
    logic [2:0] funct3;
    logic       funct7;
    logic       ZERO;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  OP, funct3, funct7, ZERO, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, illegal, instr_done
    );

    modport slave (
        output OP, funct3, funct7, ZERO, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, illegal, instr_done
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Team ALU decoder: turns the controller's ALUOp plus instruction function
// fields into the 3-bit ALU operation select.
module ALUDecoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with instr[30] set; I-type addi never subtracts.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for lw/sw/R/I/beq/jal sharing one ALU and one
// unified memory; slow memory stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit RESET_PC_UPDATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic       first_fetch;
    alu_op_t    alu_op;
    logic [2:0] alu_control;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       reg_write;
    logic       illegal_op;
    logic       done;

    // first_fetch marks the fetch right after reset so its PC update can be suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            first_fetch <= 1'b1;
        end else begin
            state <= next_state;
            if (state == S_FETCH && bus.mem_ready) begin
                first_fetch <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        done       = 1'b0;

        case (state)
            S_FETCH: begin
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready & (RESET_PC_UPDATE | ~first_fetch);
                next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            end

            // OldPC + imm lands in ALUOut here so BEQ can use it as its target.
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.OP)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default: begin
                        illegal_op = 1'b1;
                        done       = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_IMM;
                next_state = bus.OP[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end

            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                done       = 1'b1;
                next_state = S_FETCH;
            end

            // The write strobe is held until memory accepts it.
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                done       = bus.mem_ready;
                next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end

            S_EXECR: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end

            S_EXECI: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end

            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                done       = 1'b1;
                next_state = S_FETCH;
            end

            S_BEQ: begin
                src_a      = SRCA_RD1;
                src_b      = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = bus.ZERO;
                done       = 1'b1;
                next_state = S_FETCH;
            end

            // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
            S_JAL: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    ALUDecoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7      (bus.funct7),
        .op5         (bus.OP[5]),
        .alu_control (alu_control)
    );

    // Strobes are gated by rst_n so an asserted reset silences them immediately.
    assign bus.PCWrite    = pc_write & rst_n;
    assign bus.IRWrite    = ir_write & rst_n;
    assign bus.MemWrite   = mem_write & rst_n;
    assign bus.RegWrite   = reg_write & rst_n;
    assign bus.illegal    = illegal_op & rst_n;
    assign bus.instr_done = done & rst_n;

    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src_of(bus.OP);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds the expected per-cycle control
// word of each instruction from its opcode class and compares every cycle.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam bit PC_UPD = 1'b0;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       regw;
        logic       ill;
        logic       done;
    } outs_t;

    typedef struct packed {
        logic  mr;
        logic  z;
        outs_t e;
    } step_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_PC_UPDATE(PC_UPD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    step_t      q[$];
    string      tags[$];
    int         total = 0;
    int         bad = 0;
    bit         first_fetch;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;

    function automatic logic rbit();
        int unsigned r;
        r = $urandom_range(0, 1);
        return r[0];
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.pcw  = bus.PCWrite;
        o.adr  = bus.AdrSrc;
        o.memw = bus.MemWrite;
        o.irw  = bus.IRWrite;
        o.res  = bus.ResultSrc;
        o.sa   = bus.ALUSrcA;
        o.sb   = bus.ALUSrcB;
        o.alu  = bus.ALUControl;
        o.imm  = bus.ImmSrc;
        o.regw = bus.RegWrite;
        o.ill  = bus.illegal;
        o.done = bus.instr_done;
        return o;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_alu();
        if (cur_f3 == 3'b000) return (cur_op[5] && cur_f7) ? 3'b001 : 3'b000;
        if (cur_f3 == 3'b010) return 3'b101;
        if (cur_f3 == 3'b110) return 3'b011;
        if (cur_f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic outs_t base();
        outs_t o;
        o     = '0;
        o.imm = imm_of(cur_op);
        return o;
    endfunction

    function automatic outs_t fetch_word(input logic mr, input bit first);
        outs_t o;
        o     = base();
        o.sb  = 2'b10;
        o.res = 2'b10;
        o.irw = mr;
        o.pcw = mr & (PC_UPD | ~first);
        return o;
    endfunction

    task automatic push(input string t, input logic mr, input logic z, input outs_t e);
        step_t s;
        s.mr = mr;
        s.z  = z;
        s.e  = e;
        q.push_back(s);
        tags.push_back(t);
    endtask

    task automatic check(input string tag, input outs_t e);
        outs_t o;
        o = observe();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from its opcode class.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fstall, input int mstall);
        outs_t o;
        bit    legal;
        cur_op = op;
        cur_f3 = f3;
        cur_f7 = f7;
        q.delete();
        tags.delete();
        for (int i = 0; i < fstall; i++) push("fetch_stall", 1'b0, rbit(), fetch_word(1'b0, first_fetch));
        push("fetch", 1'b1, rbit(), fetch_word(1'b1, first_fetch));
        first_fetch = 1'b0;

        legal = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BQ) || (op == JL);
        o = base(); o.sa = 2'b01; o.sb = 2'b01;
        if (!legal) begin o.ill = 1'b1; o.done = 1'b1; end
        push("decode", rbit(), rbit(), o);

        if (op == LW || op == SW) begin
            o = base(); o.sa = 2'b10; o.sb = 2'b01;
            push("memadr", rbit(), rbit(), o);
            o = base(); o.adr = 1'b1;
            if (op == LW) begin
                for (int i = 0; i < mstall; i++) push("memread_stall", 1'b0, rbit(), o);
                push("memread", 1'b1, rbit(), o);
                o = base(); o.res = 2'b01; o.regw = 1'b1; o.done = 1'b1;
                push("memwb", rbit(), rbit(), o);
            end else begin
                o.memw = 1'b1;
                for (int i = 0; i < mstall; i++) push("memwrite_stall", 1'b0, rbit(), o);
                o.done = 1'b1;
                push("memwrite", 1'b1, rbit(), o);
            end
        end else if (op == RT || op == IT) begin
            o = base(); o.sa = 2'b10; o.sb = (op == IT) ? 2'b01 : 2'b00; o.alu = funct_alu();
            push(op == RT ? "execr" : "execi", rbit(), rbit(), o);
            o = base(); o.regw = 1'b1; o.done = 1'b1;
            push("aluwb", rbit(), rbit(), o);
        end else if (op == BQ) begin
            o = base(); o.sa = 2'b10; o.alu = 3'b001; o.pcw = z; o.done = 1'b1;
            push("beq", rbit(), z, o);
        end else if (op == JL) begin
            o = base(); o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
            push("jal", rbit(), rbit(), o);
            o = base(); o.regw = 1'b1; o.done = 1'b1;
            push("jal_wb", rbit(), rbit(), o);
        end
    endtask

    // Plays the queued cycles; abort_at >= 0 asserts reset mid-cycle at that step.
    task automatic checkOutput(input int abort_at);
        outs_t e;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            bus.mem_ready = q[i].mr;
            bus.ZERO      = q[i].z;
            bus.OP        = cur_op;
            bus.funct3    = cur_f3;
            bus.funct7    = cur_f7;
            @(negedge clk);
            check(tags[i], q[i].e);
            if (i == abort_at) begin
                #1;
                bus.mem_ready = 1'b1;
                rst_n = 1'b0;
                #1;
                total++;
                assert (bus.MemWrite === 1'b0) else begin
                    bad++;
                    $error("FAIL reset_memwrite observed=%b expected=0", bus.MemWrite);
                end
                e = fetch_word(1'b0, 1'b1);
                check("reset_async", e);
                first_fetch = 1'b1;
                @(posedge clk);
                #2;
                bus.mem_ready = 1'b0;
                rst_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  ops [6];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;

        rst_n = 1'b0;
        bus.OP = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 1'b0;
        bus.ZERO = 1'b0; bus.mem_ready = 1'b0;
        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0;
        first_fetch = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", fetch_word(1'b0, 1'b1));

        applyStimulus(LW, 3'b010, 1'b0, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(SW, 3'b010, 1'b0, 1'b0, 0, 2); checkOutput(-1);
        applyStimulus(RT, 3'b000, 1'b1, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(RT, 3'b000, 1'b0, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(IT, 3'b000, 1'b1, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(RT, 3'b010, 1'b0, 1'b0, 1, 0); checkOutput(-1);
        applyStimulus(BQ, 3'b000, 1'b0, 1'b1, 0, 0); checkOutput(-1);
        applyStimulus(BQ, 3'b000, 1'b0, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0); checkOutput(-1);
        applyStimulus(JL, 3'b000, 1'b0, 1'b0, 2, 0); checkOutput(-1);
        applyStimulus(SW, 3'b010, 1'b0, 1'b0, 0, 2); checkOutput(3);
        applyStimulus(RT, 3'b111, 1'b0, 1'b0, 0, 0); checkOutput(-1);

        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            if (r[31:29] == 3'b111) op = r[6:0];
            else op = ops[$urandom_range(0, 5)];
            r = $urandom;
            applyStimulus(op, r[2:0], r[3], r[4], int'(r[6:5]), int'(r[9:8]));
            checkOutput(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle control FSM for the RV32I subset lw, sw, R-type, I-type ALU, beq and jal. It sequences the shared datapath (one ALU, one unified instruction/data memory, register file) over 3-5 cycles per instruction. It replaces the single-cycle decoder when the core is built in multicycle mode. It adds a memory-ready handshake so slow memory stalls the FSM.

Parameters:
RESET_PC_UPDATE, 0, when 1 the FSM issues one PCWrite in the first Fetch after reset; when 0 that first-Fetch PCWrite is suppressed.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
OP  input  7  instruction opcode (instr[6:0]), valid from Decode onward
funct3  input  3  instr[14:12]
funct7  input  1  instr[30]
ZERO  input  1  ALU zero flag, combinational
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J; decoded from OP in every state
RegWrite  output  1  register-file write enable
illegal  output  1  one-cycle pulse for an unsupported opcode
instr_done  output  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. Reset state is FETCH.
- While rst_n=0, state is forced to FETCH and PCWrite, IRWrite, MemWrite, RegWrite, illegal and instr_done are forced to 0. This applies immediately (asynchronously), including when reset lands mid-instruction.
- Outputs are combinational from the state. ALUOp is internal: 00 add, 01 sub, 10 funct-decoded.
- ALUControl for ALUOp=10 is decoded from funct3, funct7 and OP[5]. funct3=000 gives sub only when OP[5]&funct7=1. 010 gives slt, 110 gives or, 111 gives and. Any other funct3 gives add.
- Per-state outputs (anything unlisted is 0 / 00):
  - FETCH: AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready and PCWrite=mem_ready. Stays in FETCH while mem_ready=0, otherwise goes to DECODE.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 go to MEMADR
    - 0110011 goes to EXECR
    - 0010011 goes to EXECI
    - 1100011 goes to BEQ
    - 1101111 goes to JAL
    - any other opcode: illegal=1, instr_done=1, next state FETCH, no write strobes.
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00. Goes to MEMREAD if OP[5]=0, to MEMWRITE if OP[5]=1.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds while mem_ready=0, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 and held until mem_ready=1. In the mem_ready=1 cycle instr_done=1 and next state is FETCH.
  - EXECR: SrcA=10, SrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECI: SrcA=10, SrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, PCWrite=ZERO, instr_done=1. Goes to FETCH.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes PC+4 into rd.
- Latency with mem_ready=1 throughout: lw 5 cycles, sw 4, R/I 4, jal 4, beq 3.
- mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - state encoding (4-bit)
  - ALUOp codes, ALUControl codes
  - ResultSrc / ALUSrcA / ALUSrcB / ImmSrc codes
- One sub-module: ALUDecoder, the existing team decoder, instantiated unchanged and fed the internal ALUOp.

Test Plan:
- Reset release, lw (OP=0000011), mem_ready=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done pulses in cycle 5.
- sw with mem_ready=0 for 2 cycles in MEMWRITE: MemWrite=1 for exactly 3 cycles, AdrSrc=1, RegWrite never 1, instr_done in the 3rd cycle.
- R-type, funct3=000, funct7=1: ALUControl=001 in EXECR. Same with funct7=0 gives 000. I-type, funct3=000, funct7=1 gives 000.
- beq with ZERO=1 gives PCWrite=1 in the BEQ cycle; with ZERO=0 gives PCWrite=0. Both return to FETCH after 3 cycles.
- OP=0000000: illegal=1 for one cycle in DECODE, then FETCH. PCWrite, RegWrite and MemWrite stay 0 after the fetch cycle.
- rst_n driven low mid-MEMWRITE (asynchronous, between clock edges): MemWrite drops to 0 immediately. After release the FSM is in FETCH and fetches with AdrSrc=0.
